// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU sequencer: FSM states, opcodes, ALU op codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_HALT, S_FADDR, S_FDATA, S_DECODE, S_SKIP, S_OADDR, S_ODATA, S_STORE
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_XOR  = 2'b11;

    function automatic logic [1:0] alu_sel(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_AND:  return ALU_AND;
            OP_XOR:  return ALU_XOR;
            default: return ALU_PASS;
        endcase
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FDATA) || (s == S_ODATA) || (s == S_STORE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory wait-state counter; flags expiry on the TIMEOUT-th consecutive stalled cycle.
// Latency: expired is combinational from count and en; no backpressure of its own.
module wait_timer #(
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt;

    // Saturates at LAST: the stall that would push the count to TIMEOUT is the one that expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for an accumulator CPU; Moore strobes except ld_ir/ld_ac.
// Latency 3-5 cycles per instruction plus one per mem_ready=0 cycle; bus error after TIMEOUT stalls.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter int WAIT_W   = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                sel,
    output logic                rd,
    output logic                wr,
    output logic                data_e,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic [1:0]          alu_op,
    output logic                halted,
    output logic                err
);

    state_t     state, state_nxt;
    logic       set_err, clr_err;
    logic       expired;
    logic       illegal;
    logic [2:0] op3;

    assign op3     = opcode[2:0];
    assign illegal = (OPCODE_W > 3) && (32'(opcode) > 32'd7);

    // Counter sits at zero outside the wait states, so each entry starts a fresh count.
    wait_timer #(
        .WAIT_W  (WAIT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!is_wait_state(state)),
        .en      (is_wait_state(state) && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HALT;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr_err) begin
                err <= 1'b0;
            end else if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel       = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        data_e    = 1'b0;
        ld_ir     = 1'b0;
        ld_ac     = 1'b0;
        ld_pc     = 1'b0;
        inc_pc    = 1'b0;
        alu_op    = ALU_PASS;
        halted    = 1'b0;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        case (state)
            S_HALT: begin
                halted = 1'b1;
                if (run) begin
                    clr_err   = 1'b1;
                    state_nxt = S_FADDR;
                end
            end
            S_FADDR: begin
                sel       = 1'b1;
                rd        = 1'b1;
                state_nxt = S_FDATA;
            end
            S_FDATA: begin
                sel = 1'b1;
                rd  = 1'b1;
                if (mem_ready) begin
                    ld_ir     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (expired) begin
                    set_err   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                inc_pc = 1'b1;
                if (illegal) begin
                    inc_pc    = 1'b0;
                    set_err   = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    case (op3)
                        OP_HLT: state_nxt = S_HALT;
                        OP_SKZ: state_nxt = zero ? S_SKIP : S_FADDR;
                        OP_JMP: begin
                            inc_pc    = 1'b0;
                            ld_pc     = 1'b1;
                            state_nxt = S_FADDR;
                        end
                        OP_STO:  state_nxt = S_STORE;
                        default: state_nxt = S_OADDR;
                    endcase
                end
            end
            S_SKIP: begin
                inc_pc    = 1'b1;
                state_nxt = S_FADDR;
            end
            S_OADDR: begin
                rd        = 1'b1;
                state_nxt = S_ODATA;
            end
            S_ODATA: begin
                rd     = 1'b1;
                alu_op = alu_sel(op3);
                if (mem_ready) begin
                    ld_ac     = 1'b1;
                    state_nxt = S_FADDR;
                end else if (expired) begin
                    set_err   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_STORE: begin
                data_e = 1'b1;
                wr     = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_FADDR;
                end else if (expired) begin
                    set_err   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (OPCODE_W=4); output vector checked cycle by cycle.
module tb_cpu_sequencer;

    // obs packing: {sel, rd, wr, data_e, ld_ir, ld_ac, ld_pc, inc_pc, alu_op[1:0], halted}
    localparam logic [10:0] V_HALT    = 11'b0_0_0_0_0_0_0_0_00_1;
    localparam logic [10:0] V_FADDR   = 11'b1_1_0_0_0_0_0_0_00_0;
    localparam logic [10:0] V_FDATA_R = 11'b1_1_0_0_1_0_0_0_00_0;
    localparam logic [10:0] V_DEC     = 11'b0_0_0_0_0_0_0_1_00_0;
    localparam logic [10:0] V_DEC_JMP = 11'b0_0_0_0_0_0_1_0_00_0;
    localparam logic [10:0] V_OADDR   = 11'b0_1_0_0_0_0_0_0_00_0;
    localparam logic [10:0] V_ODATA_A = 11'b0_1_0_0_0_1_0_0_01_0;
    localparam logic [10:0] V_STORE   = 11'b0_0_1_1_0_0_0_0_00_0;
    localparam logic [10:0] V_NONE    = 11'b0_0_0_0_0_0_0_0_00_0;

    localparam logic [3:0] C_HLT = 4'd0, C_SKZ = 4'd1, C_ADD = 4'd2, C_STO = 4'd6, C_JMP = 4'd7;

    logic       clk, rst_n, run, zero, mem_ready;
    logic [3:0] opcode;
    logic       sel, rd, wr, data_e, ld_ir, ld_ac, ld_pc, inc_pc, halted, err;
    logic [1:0] alu_op;
    logic [10:0] obs;
    int total = 0;
    int bad   = 0;

    assign obs = {sel, rd, wr, data_e, ld_ir, ld_ac, ld_pc, inc_pc, alu_op, halted};

    cpu_sequencer #(.OPCODE_W(4), .WAIT_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .sel(sel), .rd(rd), .wr(wr), .data_e(data_e),
        .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .alu_op(alu_op), .halted(halted), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = C_ADD;
        #3;
        total++;
        if (obs !== V_HALT || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got obs=%b err=%b want obs=%b err=0", obs, err, V_HALT);
        end
        run = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== V_HALT || err !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold_%0d: got obs=%b err=%b want obs=%b err=0", i, obs, err, V_HALT);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [10:0] ev [0:6];
        ev = '{V_HALT, V_FADDR, V_FDATA_R, V_DEC, V_OADDR, V_ODATA_A, V_FADDR};
        apply_reset();
        opcode = C_ADD; zero = 1'b0; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            total++;
            if (obs !== ev[i]) begin
                bad++;
                $display("FAIL add_cyc%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1 run = 1'b0;
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0] ops  [0:2];
        logic [1:0] alus [0:2];
        logic [10:0] want;
        ops  = '{4'd3, 4'd4, 4'd5};
        alus = '{2'b10, 2'b11, 2'b00};
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            opcode = ops[k]; mem_ready = 1'b1; run = 1'b1;
            for (int i = 0; i < 7; i++) begin
                // first op stalls one cycle in ODATA: ld_ac must wait for mem_ready
                mem_ready = !(k == 0 && i == 5);
                @(negedge clk);
                if (i == 4) begin
                    total++;
                    if (obs !== V_OADDR) begin
                        bad++;
                        $display("FAIL alu_oaddr_op%0d: got %b want %b", ops[k], obs, V_OADDR);
                    end
                end
                if (i == 5) begin
                    want = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (k != 0), 1'b0, 1'b0, alus[k], 1'b0};
                    total++;
                    if (obs !== want) begin
                        bad++;
                        $display("FAIL alu_odata_op%0d: got %b want %b", ops[k], obs, want);
                    end
                end
                @(posedge clk); #1 run = 1'b0;
            end
        end
    endtask

    task automatic test_skz();
        logic [10:0] ev [0:5];
        int incs;
        for (int z = 1; z >= 0; z--) begin
            if (z == 1) ev = '{V_HALT, V_FADDR, V_FDATA_R, V_DEC, V_DEC, V_FADDR};
            else        ev = '{V_HALT, V_FADDR, V_FDATA_R, V_DEC, V_FADDR, V_FDATA_R};
            apply_reset();
            opcode = C_SKZ; zero = z[0]; mem_ready = 1'b1; run = 1'b1;
            incs = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                incs += int'(inc_pc);
                total++;
                if (obs !== ev[i]) begin
                    bad++;
                    $display("FAIL skz_z%0d_cyc%0d: got %b want %b", z, i, obs, ev[i]);
                end
                @(posedge clk); #1 run = 1'b0;
            end
            total++;
            if (incs != z + 1) begin
                bad++;
                $display("FAIL skz_z%0d_inc_count: got %0d want %0d", z, incs, z + 1);
            end
        end
    endtask

    task automatic test_sto();
        logic [10:0] ev [0:8];
        int wrs;
        ev = '{V_HALT, V_FADDR, V_FDATA_R, V_DEC, V_STORE, V_STORE, V_STORE, V_STORE, V_FADDR};
        apply_reset();
        opcode = C_STO; run = 1'b1; wrs = 0;
        for (int i = 0; i < 9; i++) begin
            mem_ready = (i <= 3) || (i >= 7);
            @(negedge clk);
            wrs += int'(wr);
            total++;
            if (obs !== ev[i]) begin
                bad++;
                $display("FAIL sto_cyc%0d: got %b want %b", i, obs, ev[i]);
            end
            @(posedge clk); #1 run = 1'b0;
        end
        total++;
        if (wrs != 4) begin
            bad++;
            $display("FAIL sto_wr_cycles: got %0d want 4", wrs);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] want;
        apply_reset();
        opcode = C_ADD;
        for (int i = 0; i < 19; i++) begin
            mem_ready = 1'b0;
            run = (i == 0) || (i == 17);
            @(negedge clk);
            want = (i == 0 || i == 17) ? V_HALT : V_FADDR;
            total++;
            if (obs !== want || err !== (i == 17)) begin
                bad++;
                $display("FAIL timeout_cyc%0d: got obs=%b err=%b want obs=%b err=%b",
                         i, obs, err, want, (i == 17));
            end
            @(posedge clk); #1;
        end
        run = 1'b0;
    endtask

    task automatic test_wait_max();
        logic [10:0] want;
        apply_reset();
        opcode = C_HLT; run = 1'b1;
        for (int i = 0; i < 19; i++) begin
            mem_ready = (i >= 16);
            @(negedge clk);
            want = (i == 0 || i == 18) ? V_HALT :
                   (i == 16) ? V_FDATA_R : (i == 17) ? V_DEC : V_FADDR;
            total++;
            if (obs !== want || err !== 1'b0) begin
                bad++;
                $display("FAIL waitmax_cyc%0d: got obs=%b err=%b want obs=%b err=0", i, obs, err, want);
            end
            @(posedge clk); #1 run = 1'b0;
        end
    endtask

    task automatic test_illegal();
        logic [10:0] ev [0:8];
        ev = '{V_HALT, V_FADDR, V_FDATA_R, V_NONE, V_HALT, V_FADDR, V_FDATA_R, V_DEC_JMP, V_FADDR};
        apply_reset();
        opcode = 4'd9; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            total++;
            if (obs !== ev[i] || err !== (i == 4)) begin
                bad++;
                $display("FAIL illegal_cyc%0d: got obs=%b err=%b want obs=%b err=%b",
                         i, obs, err, ev[i], (i == 4));
            end
            @(posedge clk); #1;
            run = (i == 3);
            if (i == 3) opcode = C_JMP;
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        opcode = C_ADD; mem_ready = 1'b1; run = 1'b1;
        repeat (5) begin
            @(posedge clk); #1 run = 1'b0;
        end
        total++;
        if (obs !== V_ODATA_A) begin
            bad++;
            $display("FAIL rstmid_pre: got %b want %b", obs, V_ODATA_A);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== V_HALT || err !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: got obs=%b err=%b want obs=%b err=0", obs, err, V_HALT);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (obs !== V_HALT) begin
                bad++;
                $display("FAIL rstmid_after_%0d: got %b want %b", i, obs, V_HALT);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_skz();
        test_sto();
        test_timeout();
        test_wait_max();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 3, opcode width; legal values 3..5.
REQ-002 Parameter WAIT_W, default 4, width of the memory wait-state counter.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles before a bus error; must be less than 2**WAIT_W.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  single-cycle pulse; leaves S_HALT.
- opcode  in  OPCODE_W  instruction register opcode field.
- zero  in  1  accumulator-is-zero flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- sel  out  1  address source: 1 = PC, 0 = IR operand.
- rd  out  1  memory read strobe.
- wr  out  1  memory write strobe.
- data_e  out  1  accumulator drives the data bus.
- ld_ir  out  1  load the instruction register.
- ld_ac  out  1  load the accumulator.
- ld_pc  out  1  load the PC from the IR operand.
- inc_pc  out  1  increment the PC.
- alu_op  out  2  00 PASS, 01 ADD, 10 AND, 11 XOR.
- halted  out  1  FSM is in S_HALT.
- err  out  1  sticky bus-timeout or illegal-opcode flag.

Function
REQ-005 The FSM SHALL have the states S_HALT, S_FADDR, S_FDATA, S_DECODE, S_SKIP, S_OADDR, S_ODATA and S_STORE. All outputs are Moore outputs, except ld_ir and ld_ac, which are qualified by mem_ready.
REQ-006 S_HALT: all strobes are 0 and halted=1. On run=1, go to S_FADDR and clear err. Otherwise stay.
REQ-007 S_FADDR: sel=1, rd=1. Go to S_FDATA unconditionally.
REQ-008 S_FDATA: sel=1, rd=1, ld_ir=mem_ready. If mem_ready=1, go to S_DECODE.
REQ-009 S_DECODE: inc_pc=1. Next state by opcode:
- HLT: S_HALT.
- SKZ: S_SKIP if zero=1, else S_FADDR.
- JMP: ld_pc=1 and inc_pc=0 this cycle; go to S_FADDR.
- ADD, AND, XOR, LDA: S_OADDR.
- STO: S_STORE.
REQ-010 S_SKIP: inc_pc=1. Go to S_FADDR.
REQ-011 S_OADDR: sel=0, rd=1. Go to S_ODATA.
REQ-012 S_ODATA: sel=0, rd=1, alu_op from the opcode (LDA selects PASS), ld_ac=mem_ready. If mem_ready=1, go to S_FADDR.
REQ-013 S_STORE: sel=0, data_e=1, wr=1, held until mem_ready=1. Then go to S_FADDR.
REQ-014 The wait counter SHALL clear on entry to S_FDATA, S_ODATA and S_STORE, and increment each cycle there while mem_ready=0.
REQ-015 When the wait counter reaches TIMEOUT with mem_ready=0, the FSM SHALL set err=1 and go to S_HALT next cycle, with no ld_* strobe.
REQ-016 An opcode value of 8 or more (OPCODE_W>3) SHALL be illegal: in S_DECODE it sets err=1, goes to S_HALT, and inc_pc=0.
REQ-017 With zero-wait memory, instruction latency SHALL be:
- JMP, HLT, SKZ not taken: 3 cycles.
- SKZ taken: 4 cycles.
- STO: 4 cycles.
- ALU and LDA: 5 cycles.
Each mem_ready=0 cycle adds 1 cycle.
REQ-018 run outside S_HALT SHALL be ignored. mem_ready in a non-wait state SHALL be ignored.
REQ-019 alu_op SHALL read 00 in every state except S_ODATA.

Reset
REQ-020 rst_n=0 SHALL asynchronously force S_HALT, wait counter = 0, err=0 and halted=1, with all other outputs 0.
REQ-021 Reset asserted mid-instruction SHALL abandon the instruction; no ld_* or wr strobe is issued after the reset edge.
REQ-022 After rst_n deasserts, the FSM SHALL remain in S_HALT until the first run pulse.

Structure
REQ-023 The state enum, opcode constants (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7) and ALU op codes SHALL live in the shared package cpu_pkg.
REQ-024 A single sub-module, wait_timer (WAIT_W, TIMEOUT; ports clr, en, expired), is natural; the FSM stays in cpu_sequencer.

Verification
REQ-025 Directed scenarios:
- Reset, then run pulse, opcode=ADD, zero-wait memory: states FADDR, FDATA, DECODE, OADDR, ODATA; ld_ac=1 with alu_op=01 in cycle 5; back in FADDR in cycle 6.
- opcode=SKZ, zero=1: inc_pc=1 in both S_DECODE and S_SKIP (two increments); with zero=0, exactly one increment.
- opcode=STO, mem_ready low for 3 cycles: wr and data_e held for 4 cycles; wr drops the cycle after mem_ready=1.
- mem_ready held 0 in S_FDATA with TIMEOUT=15: after 15 wait cycles, err=1 and halted=1; a run pulse clears err and restarts at S_FADDR.
- OPCODE_W=4, opcode=9: err=1, S_HALT, no inc_pc; then opcode=JMP: ld_pc=1 in S_DECODE.
- rst_n pulsed low during S_ODATA with mem_ready=1: no ld_ac pulse; halted=1 immediately.
